ifetch_stage: RTL and testbench

- Instruction fetch stage; the producer feeding the 1-entry IF->DEC pipeline FIFO.
- Owns the PC and issues single-outstanding word reads to the instruction memory port.
- Pushes {pc, instruction} pairs into the FIFO, respecting its FULL flag.
- Handles redirects from branch/exception resolution by killing in-flight fetches.

---
 rtl/ifetch_stage.sv | 125 ++++++++++++
 tb/tb_ifetch_stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_stage.sv
// Instruction fetch stage: owns the PC and issues one outstanding word read at a time.
// It pushes {pc, instr} pairs into the IF->DEC FIFO and kills in-flight fetches on redirect.
module ifetch_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [XLEN-1:0]   imem_rdata,
  input  logic              fifo_full,
  output logic              fifo_push,
  output logic [2*XLEN-1:0] fifo_din
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [XLEN-1:0]     pc_q, pc_d;
  logic [XLEN-1:0]     req_pc_q, req_pc_d;
  logic                kill_q, kill_d;
  logic [2*XLEN-1:0]   hold_q, hold_d;
  logic                req_s;
  logic                push_s;
  logic [2*XLEN-1:0]   din_s;

  // Next-state, PC update and handshake strobes
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    kill_d   = kill_q;
    hold_d   = hold_q;
    req_s    = 1'b0;
    push_s   = 1'b0;
    din_s    = {req_pc_q, imem_rdata};

    case (state_q)
      ST_REQ: begin
        req_s = ~redirect_valid;
        if (req_s && imem_gnt) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + XLEN'(4);
          state_d  = ST_WAIT;
        end else begin
          state_d  = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          // A response always ends the wait; kill or redirect just drops the data.
          if (kill_q || redirect_valid) begin
            kill_d  = 1'b0;
            state_d = ST_REQ;
          end else if (!fifo_full) begin
            push_s  = 1'b1;
            state_d = ST_REQ;
          end else begin
            hold_d  = {req_pc_q, imem_rdata};
            state_d = ST_HOLD;
          end
        end else if (redirect_valid) begin
          kill_d = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_HOLD: begin
        din_s = hold_q;
        if (redirect_valid) begin
          hold_d  = {(2*XLEN){1'b0}};
          state_d = ST_REQ;
        end else if (!fifo_full) begin
          push_s  = 1'b1;
          state_d = ST_REQ;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        kill_d  = 1'b0;
        state_d = ST_REQ;
      end
    endcase

    // Redirect overrides any sequential PC advance; target is forced word-aligned.
    if (redirect_valid) begin
      pc_d = redirect_pc & ~XLEN'(3);
    end else begin
      pc_d = pc_d;
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= {XLEN{1'b0}};
      kill_q   <= 1'b0;
      hold_q   <= {(2*XLEN){1'b0}};
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      kill_q   <= kill_d;
      hold_q   <= hold_d;
    end
  end

  assign imem_req  = req_s & reset_n;
  assign imem_addr = pc_q;
  assign fifo_push = push_s & reset_n;
  assign fifo_din  = din_s;

endmodule

// File: tb/tb_ifetch_stage.sv
// Bench for ifetch_stage: cycle vectors drive the memory/FIFO side and check strobes,
// while a scoreboard queue checks every pushed {pc, instr} pair in order.
module tb_ifetch_stage;

  typedef struct packed {
    logic        rst_n;
    logic        redir;
    logic [31:0] rpc;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        full;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_push;
    logic [63:0] exp_din;
  } vec_t;

  logic        clk;
  logic        reset_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        fifo_full;
  logic        fifo_push;
  logic [63:0] fifo_din;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] sb[$];
  vec_t        tbl[$];

  ifetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .fifo_full      (fifo_full),
    .fifo_push      (fifo_push),
    .fifo_din       (fifo_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst_n, input logic redir, input logic [31:0] rpc,
                              input logic gnt, input logic rv, input logic [31:0] rdata,
                              input logic full, input logic exp_req, input logic [31:0] exp_addr,
                              input logic exp_push, input logic [63:0] exp_din);
    mk = {rst_n, redir, rpc, gnt, rv, rdata, full, exp_req, exp_addr, exp_push, exp_din};
  endfunction

  function automatic vec_t fetch(input logic [31:0] a);
    fetch = mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, a, 1'b0, 64'h0);
  endfunction

  function automatic vec_t resp(input logic [31:0] p, input logic [31:0] d);
    resp = mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, d, 1'b0, 1'b0, 32'h0, 1'b1, {p, d});
  endfunction

  function automatic vec_t idle(input logic full, input logic exp_req, input logic [31:0] a);
    idle = mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'hBAD0_BAD0, full, exp_req, a, 1'b0, 64'h0);
  endfunction

  function automatic vec_t redir(input logic [31:0] rpc, input logic gnt, input logic rv,
                                 input logic [31:0] d, input logic full);
    redir = mk(1'b1, 1'b1, rpc, gnt, rv, d, full, 1'b0, 32'h0, 1'b0, 64'h0);
  endfunction

  // Drive one cycle just after the edge, check combinational outputs mid-cycle.
  task automatic cyc(input int idx, input vec_t t);
    reset_n        = t.rst_n;
    redirect_valid = t.redir;
    redirect_pc    = t.rpc;
    imem_gnt       = t.gnt;
    imem_rvalid    = t.rv;
    imem_rdata     = t.rdata;
    fifo_full      = t.full;
    if (t.exp_push) sb.push_back(t.exp_din);
    @(negedge clk);
    chk($sformatf("imem_req[%0d]", idx), {63'h0, imem_req}, {63'h0, t.exp_req});
    chk($sformatf("fifo_push[%0d]", idx), {63'h0, fifo_push}, {63'h0, t.exp_push});
    if (t.exp_req) chk($sformatf("imem_addr[%0d]", idx), {32'h0, imem_addr}, {32'h0, t.exp_addr});
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every push must match the oldest expected pair.
  always @(negedge clk) begin
    if (fifo_push) begin
      if (fifo_full) chk("push_while_full", 64'h1, 64'h0);
      if (sb.size() == 0) begin
        chk("unexpected_push", fifo_din, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        chk("fifo_din", fifo_din, sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e_pc;
    logic [31:0] d;
    int          n_g, n_w, n_f;
    int          idx;

    // Reset, then straight-line fetches with immediate grant and 1-cycle data.
    tbl.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 64'h0));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 64'h0));
    tbl.push_back(fetch(32'h0));   tbl.push_back(resp(32'h0, 32'hA000_0000));
    tbl.push_back(fetch(32'h4));   tbl.push_back(resp(32'h4, 32'hA000_0001));
    tbl.push_back(fetch(32'h8));   tbl.push_back(resp(32'h8, 32'hA000_0002));
    // FIFO full for 3 cycles on the response: hold, then push captured pair.
    tbl.push_back(fetch(32'hC));
    tbl.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hA000_0003, 1'b1, 1'b0, 32'h0, 1'b0, 64'h0));
    tbl.push_back(idle(1'b1, 1'b0, 32'h0));
    tbl.push_back(idle(1'b1, 1'b0, 32'h0));
    tbl.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'hBAD0_BAD0, 1'b0, 1'b0, 32'h0, 1'b1,
                     {32'hC, 32'hA000_0003}));
    tbl.push_back(idle(1'b0, 1'b1, 32'h10));
    tbl.push_back(fetch(32'h10));
    // Redirect while waiting: in-flight 0xDEAD is killed.
    tbl.push_back(redir(32'h100, 1'b0, 1'b0, 32'h0, 1'b0));
    tbl.push_back(idle(1'b0, 1'b0, 32'h0));
    tbl.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_DEAD, 1'b0, 1'b0, 32'h0, 1'b0, 64'h0));
    tbl.push_back(fetch(32'h100)); tbl.push_back(resp(32'h100, 32'hA000_0004));
    // Redirect in the same cycle as rvalid, unaligned target.
    tbl.push_back(fetch(32'h104));
    tbl.push_back(redir(32'h203, 1'b0, 1'b1, 32'hA000_0005, 1'b0));
    tbl.push_back(fetch(32'h200)); tbl.push_back(resp(32'h200, 32'hA000_0006));
    // Redirect in REQ with grant high: no request issues.
    tbl.push_back(redir(32'h300, 1'b1, 1'b0, 32'h0, 1'b0));
    tbl.push_back(fetch(32'h300)); tbl.push_back(resp(32'h300, 32'hA000_0007));
    // Redirect while holding drops the held pair.
    tbl.push_back(fetch(32'h304));
    tbl.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hA000_0008, 1'b1, 1'b0, 32'h0, 1'b0, 64'h0));
    tbl.push_back(redir(32'h400, 1'b0, 1'b0, 32'h0, 1'b0));
    tbl.push_back(fetch(32'h400)); tbl.push_back(resp(32'h400, 32'hA000_0009));
    // Second redirect while already killing: latest target wins.
    tbl.push_back(fetch(32'h404));
    tbl.push_back(redir(32'h500, 1'b0, 1'b0, 32'h0, 1'b0));
    tbl.push_back(redir(32'h600, 1'b0, 1'b0, 32'h0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_DEAD, 1'b0, 1'b0, 32'h0, 1'b0, 64'h0));
    tbl.push_back(fetch(32'h600)); tbl.push_back(resp(32'h600, 32'hA000_000A));
    // PC wrap from the top of the address space.
    tbl.push_back(redir(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b0));
    tbl.push_back(fetch(32'hFFFF_FFFC)); tbl.push_back(resp(32'hFFFF_FFFC, 32'hA000_000B));
    tbl.push_back(fetch(32'h0));

    idx = 0;
    foreach (tbl[i]) begin
      cyc(idx, tbl[i]);
      idx++;
    end

    // Reset asserted mid-WAIT; stale rvalid during and after reset is ignored.
    cyc(idx, mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 64'h0)); idx++;
    cyc(idx, mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h5757_5757, 1'b0, 1'b0, 32'h0, 1'b0, 64'h0)); idx++;
    cyc(idx, mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h5757_5757, 1'b0, 1'b1, 32'h0, 1'b0, 64'h0)); idx++;
    cyc(idx, fetch(32'h0)); idx++;
    cyc(idx, resp(32'h0, 32'hA000_000C)); idx++;

    // Sequential stream with random grant delay, data latency and FIFO backpressure.
    e_pc = 32'h4;
    for (int k = 0; k < 10; k++) begin
      n_g = int'($urandom_range(2));
      n_w = int'($urandom_range(2));
      n_f = int'($urandom_range(2));
      d   = $urandom;
      for (int j = 0; j < n_g; j++) begin
        cyc(idx, idle(1'b0, 1'b1, e_pc)); idx++;
      end
      cyc(idx, fetch(e_pc)); idx++;
      for (int j = 0; j < n_w; j++) begin
        cyc(idx, idle(1'b0, 1'b0, 32'h0)); idx++;
      end
      if (n_f == 0) begin
        cyc(idx, resp(e_pc, d)); idx++;
      end else begin
        cyc(idx, mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, d, 1'b1, 1'b0, 32'h0, 1'b0, 64'h0)); idx++;
        for (int j = 1; j < n_f; j++) begin
          cyc(idx, idle(1'b1, 1'b0, 32'h0)); idx++;
        end
        cyc(idx, mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'hBAD0_BAD0, 1'b0, 1'b0, 32'h0, 1'b1,
                    {e_pc, d})); idx++;
      end
      e_pc = e_pc + 32'h4;
    end
    cyc(idx, idle(1'b0, 1'b1, e_pc)); idx++;

    chk("sb_drained", 64'(sb.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
